// File: rtl/inst_encoder_pkg.sv
// Shared RV32 encoding definitions: opcode constants, instruction formats,
// and an immediate decoder usable by any consumer of encoded words.
package inst_encoder_pkg;

    localparam int INST_WIDTH = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [INST_WIDTH-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OP_R:                      fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
            OP_STORE:                  fmt = FMT_S;
            OP_BRANCH:                 fmt = FMT_B;
            OP_LUI, OP_AUIPC:          fmt = FMT_U;
            OP_JAL:                    fmt = FMT_J;
            default:                   fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

    // Inverse of the scatter performed by inst_pack; R-type and unknown return 0.
    function automatic logic [INST_WIDTH-1:0] decode_imm(input logic [INST_WIDTH-1:0] inst);
        logic [INST_WIDTH-1:0] imm;
        case (opcode_fmt(inst[6:0]))
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32 field packer: scatters the immediate for the opcode's
// format and flags immediates the format cannot represent exactly.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [6:0]            i_opcode,
    input  logic [4:0]            i_rd,
    input  logic [4:0]            i_rs1,
    input  logic [4:0]            i_rs2,
    input  logic [2:0]            i_funct3,
    input  logic [6:0]            i_funct7,
    input  logic [31:0]           i_imm,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_err
);

    logic w_fits12;
    logic w_fits13;
    logic w_fits21;
    logic w_u_low_zero;

    // An immediate fits N signed bits when every bit above N-1 copies bit N-1.
    assign w_fits12     = (&i_imm[31:11]) || !(|i_imm[31:11]);
    assign w_fits13     = (&i_imm[31:12]) || !(|i_imm[31:12]);
    assign w_fits21     = (&i_imm[31:20]) || !(|i_imm[31:20]);
    assign w_u_low_zero = !(|i_imm[11:0]);

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        o_inst = NOP;
        o_err  = 1'b1;
        case (opcode_fmt(i_opcode))
            FMT_R: begin
                o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_err  = 1'b0;
            end
            FMT_I: begin
                o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err  = !w_fits12;
            end
            FMT_S: begin
                o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err  = !w_fits12;
            end
            FMT_B: begin
                o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
                o_err  = !w_fits13 || i_imm[0];
            end
            FMT_U: begin
                o_inst = {i_imm[31:12], i_rd, i_opcode};
                o_err  = !w_u_low_zero;
            end
            FMT_J: begin
                o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err  = !w_fits21 || i_imm[0];
            end
            default: begin
                o_inst = NOP;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: one-register valid/ready stage that packs
// requests into RV32 words at consecutive byte addresses and counts errors.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [6:0]               i_opcode,
    input  logic [4:0]               i_rd,
    input  logic [4:0]               i_rs1,
    input  logic [4:0]               i_rs2,
    input  logic [2:0]               i_funct3,
    input  logic [6:0]               i_funct7,
    input  logic [31:0]              i_imm,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [INST_WIDTH-1:0]    o_inst,
    output logic [ADDR_WIDTH-1:0]    o_addr,
    output logic                     o_err,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

    logic [INST_WIDTH-1:0]    w_inst;
    logic                     w_err;
    logic                     w_accept;

    logic                     r_valid;
    logic [INST_WIDTH-1:0]    r_inst;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [ADDR_WIDTH-1:0]    r_addr_cnt;
    logic                     r_err;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    inst_pack u_pack (
        .i_opcode (i_opcode),
        .i_rd     (i_rd),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_funct3 (i_funct3),
        .i_funct7 (i_funct7),
        .i_imm    (i_imm),
        .o_inst   (w_inst),
        .o_err    (w_err)
    );

    // The stage may refill in the same cycle it drains, so flow has no bubbles.
    assign o_ready  = !i_clr && (!r_valid || i_ready);
    assign w_accept = i_valid && o_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_inst     <= '0;
            r_addr     <= '0;
            r_err      <= 1'b0;
            r_addr_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (i_clr) begin
            // The error count is history, not pipeline state, so clear leaves it alone.
            r_valid    <= 1'b0;
            r_inst     <= '0;
            r_addr     <= '0;
            r_err      <= 1'b0;
            r_addr_cnt <= '0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_inst     <= w_inst;
            r_addr     <= r_addr_cnt;
            r_err      <= w_err;
            r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(4);
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_inst    = r_inst;
    assign o_addr    = r_addr;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a transaction-level reference model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_inst_encoder;

    localparam int AW  = 4;
    localparam int ECW = 3;
    localparam int ERR_MAX = (1 << ECW) - 1;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_clr;
    logic        i_valid;
    logic        o_ready;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_imm;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [AW-1:0]  o_addr;
    logic        o_err;
    logic [ECW-1:0] o_err_cnt;

    inst_encoder #(
        .ADDR_WIDTH    (AW),
        .ERR_CNT_WIDTH (ECW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (i_clr),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_opcode  (i_opcode),
        .i_rd      (i_rd),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_funct3  (i_funct3),
        .i_funct7  (i_funct7),
        .i_imm     (i_imm),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_inst    (o_inst),
        .o_addr    (o_addr),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    // Format codes used only by the reference model.
    localparam int K_R = 0, K_I = 1, K_S = 2, K_B = 3, K_U = 4, K_J = 5, K_BAD = 6;

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'h33:                return K_R;
            7'h13, 7'h03, 7'h67:  return K_I;
            7'h23:                return K_S;
            7'h63:                return K_B;
            7'h37, 7'h17:         return K_U;
            7'h6f:                return K_J;
            default:              return K_BAD;
        endcase
    endfunction

    // Reference encoding from the format tables using shifts, masks and integer range tests.
    function automatic void model_encode(input req_t r, output logic [31:0] w, output bit e);
        logic [31:0] op, rd, rs1, rs2, f3, f7, imm;
        longint s;
        op = 32'(r.op); rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        f3 = 32'(r.f3); f7 = 32'(r.f7); imm = r.imm;
        s = longint'($signed(r.imm));
        case (kind_of(r.op))
            K_R: begin
                w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = 0;
            end
            K_I: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = (s < -2048) || (s > 2047);
            end
            K_S: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
                e = (s < -2048) || (s > 2047);
            end
            K_B: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | op;
                e = (s < -4096) || (s > 4095) || ((imm & 1) != 0);
            end
            K_U: begin
                w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
                e = (imm & 32'hFFF) != 0;
            end
            K_J: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
                e = (s < -1048576) || (s > 1048575) || ((imm & 1) != 0);
            end
            default: begin
                w = 32'h0000_0013;
                e = 1;
            end
        endcase
    endfunction

    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        logic [31:0] v;
        case (kind_of(w[6:0]))
            K_I:     v = 32'($signed(w[31:20]));
            K_S:     v = 32'($signed({w[31:25], w[11:7]}));
            K_B:     v = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            K_U:     v = {w[31:12], 12'h000};
            K_J:     v = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Reference model state: the word in the output stage, accepts since clear, total errors.
    bit          m_valid = 0;
    logic [31:0] m_inst;
    logic [31:0] m_addr;
    bit          m_err;
    req_t        m_req;
    int          m_accepts = 0;
    int          m_errs = 0;

    always @(negedge i_clk) begin
        logic [31:0] w;
        bit          e;
        req_t        cur;
        bit          exp_ready;
        if (!i_rst_n) begin
            m_valid   = 0;
            m_accepts = 0;
            m_errs    = 0;
        end
        exp_ready = !i_clr && (!m_valid || i_ready);
        check("o_valid", 32'(o_valid), 32'(m_valid));
        check("o_ready", 32'(o_ready), 32'(exp_ready));
        check("o_err_cnt", 32'(o_err_cnt), 32'((m_errs > ERR_MAX) ? ERR_MAX : m_errs));
        if (m_valid) begin
            check("o_inst", o_inst, m_inst);
            check("o_addr", 32'(o_addr), m_addr);
            check("o_err", 32'(o_err), 32'(m_err));
            if (!m_err && kind_of(m_req.op) != K_R && kind_of(m_req.op) != K_BAD)
                check("imm_roundtrip", dec_imm(o_inst), m_req.imm);
        end
        if (i_rst_n) begin
            if (i_clr) begin
                m_valid   = 0;
                m_accepts = 0;
            end else if (i_valid && exp_ready) begin
                cur = '{op: i_opcode, rd: i_rd, rs1: i_rs1, rs2: i_rs2,
                        f3: i_funct3, f7: i_funct7, imm: i_imm};
                model_encode(cur, w, e);
                m_valid = 1;
                m_inst  = w;
                m_err   = e;
                m_req   = cur;
                m_addr  = 32'((m_accepts * 4) % (1 << AW));
                m_accepts++;
                if (e) m_errs++;
            end else if (m_valid && i_ready) begin
                m_valid = 0;
            end
        end
    end

    function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm);
        req_t r;
        r = '{op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm};
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input req_t r);
        i_opcode = r.op; i_rd = r.rd; i_rs1 = r.rs1; i_rs2 = r.rs2;
        i_funct3 = r.f3; i_funct7 = r.f7; i_imm = r.imm;
        i_valid  = 1'b1;
    endtask

    req_t addi, sw, beq, jal3, bad0, lui, auipc;
    req_t vecs[13];

    initial begin
        addi  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        sw    = mk(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8);
        beq   = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        jal3  = mk(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        bad0  = mk(7'h00, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        lui   = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        auipc = mk(7'h17, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000);

        vecs[0]  = mk(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF);
        vecs[1]  = mk(7'h03, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, 32'd2047);
        vecs[2]  = mk(7'h67, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        vecs[3]  = mk(7'h63, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'd4094);
        vecs[4]  = mk(7'h6f, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
        vecs[5]  = mk(7'h03, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, 32'd2048);
        vecs[6]  = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F7FF);
        vecs[7]  = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
        vecs[8]  = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd2);
        vecs[9]  = mk(7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001);
        vecs[10] = mk(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        vecs[11] = mk(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        vecs[12] = mk(7'h7f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        i_rst_n = 1'b0; i_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_opcode = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
        i_funct3 = '0; i_funct7 = '0; i_imm = '0;

        // Reset state
        #3;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        tick(); tick();

        // ADDI accepted on the first edge after reset release
        i_rst_n = 1'b1;
        send(addi);
        tick();
        i_valid = 1'b0;
        #2;
        check("addi_valid", 32'(o_valid), 32'd1);
        check("addi_inst", o_inst, 32'hFFF0_0093);
        check("addi_err", 32'(o_err), 32'd0);
        check("addi_addr", 32'(o_addr), 32'd0);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;

        // Store then branch back to back
        send(sw);
        tick();
        send(beq);
        #2;
        check("sw_inst", o_inst, 32'h0021_A423);
        check("sw_addr", 32'(o_addr), 32'd0);
        tick();
        i_valid = 1'b0;
        #2;
        check("beq_valid", 32'(o_valid), 32'd1);
        check("beq_inst", o_inst, 32'hFE00_0EE3);
        check("beq_addr", 32'(o_addr), 32'd4);
        tick();

        // Error cases
        send(jal3);
        tick();
        send(bad0);
        #2;
        check("jal_err", 32'(o_err), 32'd1);
        check("jal_err_cnt", 32'(o_err_cnt), 32'd1);
        tick();
        i_valid = 1'b0;
        #2;
        check("bad_inst", o_inst, 32'h0000_0013);
        check("bad_err", 32'(o_err), 32'd1);
        check("bad_err_cnt", 32'(o_err_cnt), 32'd2);
        tick();

        // Backpressure: LUI held while AUIPC waits
        i_ready = 1'b0;
        send(lui);
        tick();
        send(auipc);
        #2;
        check("lui_inst", o_inst, 32'h1234_52B7);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_inst", o_inst, 32'h1234_52B7);
            check("bp_addr", 32'(o_addr), 32'd0);
        end
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        #2;
        check("auipc_inst", o_inst, 32'hFFFF_F317);
        check("auipc_addr", 32'(o_addr), 32'd4);
        tick();

        // Address wrap, immediate boundaries and error counter saturation
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        for (int i = 0; i < 13; i++) begin
            send(vecs[i]);
            tick();
            if (i == 0) begin
                #2;
                check("sub_inst", o_inst, 32'h4031_00B3);
            end
            if (i == 4) begin
                #2;
                check("wrap_addr", 32'(o_addr), 32'd0);
            end
        end
        i_valid = 1'b0;
        #2;
        check("err_cnt_sat", 32'(o_err_cnt), 32'd7);

        // Clear while a request is offered
        send(addi);
        i_clr = 1'b1;
        #1;
        check("clr_ready", 32'(o_ready), 32'd0);
        tick();
        i_clr = 1'b0;
        #2;
        check("clr_valid", 32'(o_valid), 32'd0);
        check("clr_err_cnt", 32'(o_err_cnt), 32'd7);
        tick();
        i_valid = 1'b0;
        #2;
        check("post_clr_addr", 32'(o_addr), 32'd0);
        check("post_clr_inst", o_inst, 32'hFFF0_0093);
        tick();

        // Asynchronous reset between edges with a word held
        i_ready = 1'b0;
        send(lui);
        tick();
        i_valid = 1'b0;
        #1;
        i_rst_n = 1'b0;
        #2;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_inst", o_inst, 32'd0);
        check("arst_addr", 32'(o_addr), 32'd0);
        check("arst_err", 32'(o_err), 32'd0);
        check("arst_err_cnt", 32'(o_err_cnt), 32'd0);
        tick(); tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        send(auipc);
        tick();
        i_valid = 1'b0;
        #2;
        check("post_rst_inst", o_inst, 32'hFFFF_F317);
        check("post_rst_addr", 32'(o_addr), 32'd0);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
